midi_tx: RTL and testbench

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_tx.sv | 147 ++++++++++++++
 tb/tb_midi_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI Note On/Off transmitter with 8N1 serializer and running status
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module midi_tx #(
  parameter int MIDI_CHANNEL   = 0,
  parameter int CLKS_PER_BIT   = 384,
  parameter bit RUNNING_STATUS = 1
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          noteOnReq_i,
  input  logic                          noteOffReq_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0] note_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0] velocity_i,
  output logic                          ready_o,
  output logic                          txData_o,
  output logic                          msgDone_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        CHAN         = 4'(MIDI_CHANNEL);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baudCnt;
  logic [2:0]          bitCnt;
  logic [1:0]          byteIdx;
  logic [7:0]          statusReg;
  logic [6:0]          noteReg;
  logic [6:0]          velReg;
  logic [7:0]          lastStatus;

  logic                accept;
  logic [7:0]          statusNext;
  logic                skipStatus;
  logic                baudEnd;
  logic                lastByte;
  logic [7:0]          curByte;

  // Bit 7 of the payload inputs is deliberately dropped (MIDI data bytes are 7-bit).
  logic unusedPayloadMsb;
  assign unusedPayloadMsb = ^{note_i[`MIDI_PAYLOAD_BITS-1:7], velocity_i[`MIDI_PAYLOAD_BITS-1:7]};

  // Request decode: Note On wins a tie; status omitted when it repeats the last one sent.
  always_comb begin
    accept     = ready_o & (noteOnReq_i | noteOffReq_i);
    statusNext = noteOnReq_i ? {4'h9, CHAN} : {4'h8, CHAN};
    skipStatus = RUNNING_STATUS && (statusNext == lastStatus);
    baudEnd    = (baudCnt == BAUD_LAST);
    lastByte   = (byteIdx == 2'd2);
  end

  // Select the byte currently on the wire.
  always_comb begin
    curByte = statusReg;
    case (byteIdx)
      2'd1:    curByte = {1'b0, noteReg};
      2'd2:    curByte = {1'b0, velReg};
      default: curByte = statusReg;
    endcase
  end

  // Message FSM: capture request, then shift start/data/stop per byte with registered outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= IDLE;
      baudCnt    <= '0;
      bitCnt     <= '0;
      byteIdx    <= '0;
      statusReg  <= '0;
      noteReg    <= '0;
      velReg     <= '0;
      lastStatus <= 8'h00;
      ready_o    <= 1'b1;
      txData_o   <= 1'b1;
      msgDone_o  <= 1'b0;
    end else begin
      msgDone_o <= 1'b0;
      case (state)
        IDLE: begin
          txData_o <= 1'b1;
          ready_o  <= 1'b1;
          if (accept) begin
            noteReg   <= note_i[6:0];
            velReg    <= velocity_i[6:0];
            statusReg <= statusNext;
            byteIdx   <= skipStatus ? 2'd1 : 2'd0;
            if (!skipStatus) lastStatus <= statusNext;
            baudCnt   <= '0;
            bitCnt    <= '0;
            txData_o  <= 1'b0;
            ready_o   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baudEnd) begin
            baudCnt  <= '0;
            bitCnt   <= '0;
            txData_o <= curByte[0];
            state    <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              txData_o  <= 1'b1;
              msgDone_o <= (CLKS_PER_BIT == 1) && lastByte;
              state     <= STOP;
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              txData_o <= curByte[bitCnt + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (lastByte) begin
              ready_o <= 1'b1;
              state   <= IDLE;
            end else begin
              byteIdx  <= byteIdx + 2'd1;
              txData_o <= 1'b0;
              state    <= START;
            end
          end else begin
            baudCnt   <= baudCnt + 1'b1;
            msgDone_o <= (CLKS_PER_BIT > 1) && lastByte && (baudCnt == BAUD_PRELAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - directed self-checking bench for midi_tx
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module tb_midi_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;

  logic clk, nrst;
  logic onReq, offReq, onReq0, offReq0;
  logic [7:0] note, vel;
  logic ready, tx, done;
  logic ready0, tx0, done0;

  int checks = 0;
  int errors = 0;

  logic txLog    [0:159];
  logic doneLog  [0:159];
  logic readyLog [0:159];

  midi_tx #(.MIDI_CHANNEL(0), .CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) dut (
    .clk_i(clk), .nrst_i(nrst), .noteOnReq_i(onReq), .noteOffReq_i(offReq),
    .note_i(note), .velocity_i(vel), .ready_o(ready), .txData_o(tx), .msgDone_o(done)
  );

  midi_tx #(.MIDI_CHANNEL(0), .CLKS_PER_BIT(CPB), .RUNNING_STATUS(0)) dut0 (
    .clk_i(clk), .nrst_i(nrst), .noteOnReq_i(onReq0), .noteOffReq_i(offReq0),
    .note_i(note), .velocity_i(vel), .ready_o(ready0), .txData_o(tx0), .msgDone_o(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Request one message, log nBytes*BYTE_CYC+2 cycles, decode and check it.
  task automatic send_msg(input bit sel0, input bit on, input bit off,
                          input logic [7:0] nt, input logic [7:0] vl, input int nBytes,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input int injectAt, input string name);
    logic [7:0] expB [3];
    logic [7:0] got;
    int waitCnt;
    int doneCnt;
    int endC;
    expB[0] = e0; expB[1] = e1; expB[2] = e2;
    endC = nBytes * BYTE_CYC;
    waitCnt = 0;
    while (!(sel0 ? ready0 : ready) && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (waitCnt >= 400) begin
      errors++;
      $display("FAIL %s ready_wait: ready=0 required 1", name);
    end
    note = nt; vel = vl;
    if (sel0) begin onReq0 = on; offReq0 = off; end
    else      begin onReq  = on; offReq  = off; end
    @(negedge clk);
    onReq = 0; offReq = 0; onReq0 = 0; offReq0 = 0;
    note = ~nt; vel = ~vl;
    for (int c = 0; c < endC + 2; c++) begin
      if (c > 0) @(negedge clk);
      txLog[c]    = sel0 ? tx0 : tx;
      doneLog[c]  = sel0 ? done0 : done;
      readyLog[c] = sel0 ? ready0 : ready;
      if (c == injectAt) begin
        if (sel0) offReq0 = 1; else offReq = 1;
      end else begin
        offReq0 = 0; offReq = 0;
      end
    end
    checks++;
    if (readyLog[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_drop: got %b required 0", name, readyLog[0]);
    end
    checks++;
    if (txLog[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s start_latency: tx=%b required 0", name, txLog[0]);
    end
    for (int b = 0; b < nBytes; b++) begin
      for (int j = 0; j < 8; j++) got[j] = txLog[b*BYTE_CYC + CPB*(j+1) + 2];
      checks++;
      if (got !== expB[b] || txLog[b*BYTE_CYC + 2] !== 1'b0 || txLog[b*BYTE_CYC + 9*CPB + 2] !== 1'b1) begin
        errors++;
        $display("FAIL %s byte%0d: got %h start=%b stop=%b required %h start=0 stop=1", name, b, got,
                 txLog[b*BYTE_CYC + 2], txLog[b*BYTE_CYC + 9*CPB + 2], expB[b]);
      end
    end
    doneCnt = 0;
    for (int c = 0; c < endC + 2; c++) if (doneLog[c] === 1'b1) doneCnt++;
    checks++;
    if (doneCnt != 1 || doneLog[endC-1] !== 1'b1) begin
      errors++;
      $display("FAIL %s msg_done: pulses=%0d at_last=%b required 1 pulse at cycle %0d", name, doneCnt, doneLog[endC-1], endC-1);
    end
    checks++;
    if (readyLog[endC-1] !== 1'b0 || readyLog[endC] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_return: before=%b after=%b required 0 then 1", name, readyLog[endC-1], readyLog[endC]);
    end
  endtask

  // Line must stay idle and ready for n cycles with no requests.
  task automatic idle_watch(input bit sel0, input int n, input string name);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if ((sel0 ? tx0 : tx) !== 1'b1 || (sel0 ? ready0 : ready) !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: %0d non-idle cycles, required 0", name, bad);
    end
  endtask

  task automatic test_reset;
    onReq = 0; offReq = 0; onReq0 = 0; offReq0 = 0; note = 0; vel = 0;
    nrst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b ready=%b done=%b tx0=%b ready0=%b done0=%b required 1 1 0", tx, ready, done, tx0, ready0, done0);
    end
    nrst = 1;
    idle_watch(0, 5, "post_reset");
  endtask

  task automatic test_note_on;
    send_msg(0, 1, 0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, -1, "note_on");
  endtask

  task automatic test_running_status;
    send_msg(0, 1, 0, 8'h40, 8'h50, 2, 8'h40, 8'h50, 8'h00, -1, "running_status");
  endtask

  task automatic test_no_running_status;
    send_msg(1, 1, 0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, -1, "rs0_first");
    send_msg(1, 1, 0, 8'h40, 8'h50, 3, 8'h90, 8'h40, 8'h50, -1, "rs0_second");
  endtask

  task automatic test_priority;
    send_msg(1, 1, 1, 8'h3C, 8'h7F, 3, 8'h90, 8'h3C, 8'h7F, -1, "priority");
    idle_watch(1, 20, "priority_no_off");
  endtask

  task automatic test_drop_busy;
    send_msg(0, 1, 0, 8'h10, 8'h20, 2, 8'h10, 8'h20, 8'h00, 10, "busy_msg");
    idle_watch(0, 20, "busy_dropped");
    send_msg(0, 0, 1, 8'hBC, 8'h00, 3, 8'h80, 8'h3C, 8'h00, -1, "note_off");
  endtask

  task automatic test_reset_midframe;
    note = 8'h3C; vel = 8'h64; onReq = 1;
    @(negedge clk);
    onReq = 0;
    repeat (50) @(negedge clk);
    nrst = 0;
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: tx=%b ready=%b done=%b required 1 1 0", tx, ready, done);
    end
    @(negedge clk);
    nrst = 1;
    idle_watch(0, 60, "no_resume");
    send_msg(0, 1, 0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, -1, "after_reset");
  endtask

  initial begin
    nrst = 0;
    @(negedge clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_no_running_status();
    test_priority();
    test_drop_busy();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
